// File: rtl/controle_pkg.sv
// Shared definitions for the ALU controller: FSM states, ALU operation codes
// and instruction field positions.
package controle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_BRANCH = 3'd4
  } state_t;

  localparam logic [4:0] ALU_MOV  = 5'h00;
  localparam logic [4:0] ALU_ADD  = 5'h01;
  localparam logic [4:0] ALU_SUB  = 5'h02;
  localparam logic [4:0] ALU_MUL  = 5'h03;
  localparam logic [4:0] ALU_DIV  = 5'h04;
  localparam logic [4:0] ALU_AND  = 5'h05;
  localparam logic [4:0] ALU_OR   = 5'h06;
  localparam logic [4:0] ALU_XOR  = 5'h07;
  localparam logic [4:0] ALU_NOR  = 5'h08;
  localparam logic [4:0] ALU_REM  = 5'h09;
  localparam logic [4:0] ALU_SLT  = 5'h0A;
  localparam logic [4:0] ALU_SLTU = 5'h0B;
  localparam logic [4:0] ALU_SLL  = 5'h0C;
  localparam logic [4:0] ALU_SRL  = 5'h0D;
  localparam logic [4:0] ALU_SRA  = 5'h0E;
  localparam logic [4:0] ALU_LUI  = 5'h0F;
  localparam logic [4:0] ALU_MULH = 5'h10;
  localparam logic [4:0] ALU_BEQ  = 5'h11;
  localparam logic [4:0] ALU_BNE  = 5'h12;
  localparam logic [4:0] ALU_SGE  = 5'h13;
  localparam logic [4:0] ALU_LAST = ALU_SGE;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS_MSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/controle_ula_decodificador.sv
// Combinational opcode decoder: ALU operation, operand-B select and class flags.
module decodificador
  import controle_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic [4:0] o_alu_op,
  output logic       o_imm_sel,
  output logic       o_is_branch,
  output logic       o_is_div,
  output logic       o_illegal
);

  logic [4:0] w_op;

  assign w_op        = i_opcode[4:0];
  assign o_alu_op    = w_op;
  assign o_is_branch = (w_op == ALU_BEQ) || (w_op == ALU_BNE);
  // Branches always compare two registers, so the immediate bit is ignored.
  assign o_imm_sel   = i_opcode[5] && !o_is_branch;
  assign o_is_div    = (w_op == ALU_DIV) || (w_op == ALU_REM);
  assign o_illegal   = (w_op > ALU_LAST);

endmodule

// File: rtl/controle_ula.sv
// Multi-cycle ALU controller: accepts one instruction, reads operands, drives
// the ALU, then performs register writeback or a branch redirect.
module controle_ula
  import controle_pkg::*;
#(
  parameter bit R0_WRITE_EN = 1'b0
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_flag,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        br_valid,
  output logic [31:0] br_target,
  output logic        err_illegal,
  output logic        err_div0,
  output logic        busy
);

  state_t      r_state, w_state;

  logic        r_instr_ready, w_instr_ready;
  logic        r_busy, w_busy;
  logic [4:0]  r_rs_addr, w_rs_addr;
  logic [4:0]  r_rt_addr, w_rt_addr;
  logic [4:0]  r_alu_op, w_alu_op;
  logic [31:0] r_alu_a, w_alu_a;
  logic [31:0] r_alu_b, w_alu_b;
  logic [4:0]  r_alu_shamt, w_alu_shamt;
  logic        r_wb_valid, w_wb_valid;
  logic [4:0]  r_wb_addr, w_wb_addr;
  logic [31:0] r_wb_data, w_wb_data;
  logic        r_br_valid, w_br_valid;
  logic [31:0] r_br_target, w_br_target;
  logic        r_err_illegal, w_err_illegal;
  logic        r_err_div0, w_err_div0;

  logic [4:0]  r_rd, w_rd;
  logic [4:0]  r_shamt, w_shamt;
  logic [15:0] r_imm, w_imm;
  logic [31:0] r_pc, w_pc;
  logic [4:0]  r_op, w_op;
  logic        r_imm_sel, w_imm_sel;
  logic        r_is_branch, w_is_branch;
  logic        r_is_div, w_is_div;
  logic        r_illegal, w_illegal;

  logic [4:0]  w_dec_op;
  logic        w_dec_imm_sel, w_dec_is_branch, w_dec_is_div, w_dec_illegal;

  decodificador u_dec (
    .i_opcode    (instr[OPC_MSB:OPC_LSB]),
    .o_alu_op    (w_dec_op),
    .o_imm_sel   (w_dec_imm_sel),
    .o_is_branch (w_dec_is_branch),
    .o_is_div    (w_dec_is_div),
    .o_illegal   (w_dec_illegal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state;
  end

  always_comb begin
    w_state       = r_state;
    w_rs_addr     = r_rs_addr;
    w_rt_addr     = r_rt_addr;
    w_alu_op      = r_alu_op;
    w_alu_a       = r_alu_a;
    w_alu_b       = r_alu_b;
    w_alu_shamt   = r_alu_shamt;
    w_wb_valid    = r_wb_valid;
    w_wb_addr     = r_wb_addr;
    w_wb_data     = r_wb_data;
    w_br_valid    = 1'b0;
    w_br_target   = r_br_target;
    w_err_illegal = 1'b0;
    w_err_div0    = 1'b0;
    w_rd          = r_rd;
    w_shamt       = r_shamt;
    w_imm         = r_imm;
    w_pc          = r_pc;
    w_op          = r_op;
    w_imm_sel     = r_imm_sel;
    w_is_branch   = r_is_branch;
    w_is_div      = r_is_div;
    w_illegal     = r_illegal;

    case (r_state)
      // IDLE -> READ: capture instruction fields and present register addresses
      ST_IDLE: begin
        if (instr_valid && r_instr_ready) begin
          w_rd          = instr[RD_MSB:RD_LSB];
          w_shamt       = instr[SH_MSB:SH_LSB];
          w_imm         = instr[IMM_MSB:IMM_LSB];
          w_pc          = pc_in;
          w_op          = w_dec_op;
          w_imm_sel     = w_dec_imm_sel;
          w_is_branch   = w_dec_is_branch;
          w_is_div      = w_dec_is_div;
          w_illegal     = w_dec_illegal;
          w_rs_addr     = instr[RS_MSB:RS_LSB];
          w_rt_addr     = instr[RT_MSB:RT_LSB];
          w_err_illegal = w_dec_illegal;
          w_state       = ST_READ;
        end
      end
      // READ -> EXEC: register-file data becomes the ALU operands
      ST_READ: begin
        if (r_illegal) begin
          w_state = ST_IDLE;
        end else begin
          w_alu_op    = r_op;
          w_alu_a     = rs_data;
          w_alu_b     = r_imm_sel ? sext16(r_imm) : rt_data;
          w_alu_shamt = r_shamt;
          w_state     = ST_EXEC;
        end
      end
      // EXEC -> WB/BRANCH/IDLE: latch ALU result and flag
      ST_EXEC: begin
        if (r_is_div && (r_alu_b == 32'd0)) begin
          w_err_div0 = 1'b1;
          w_state    = ST_IDLE;
        end else if (r_is_branch) begin
          w_br_valid = alu_flag;
          if (alu_flag) w_br_target = r_pc + 32'd1 + sext16(r_imm);
          w_state = ST_BRANCH;
        end else if ((r_rd == 5'd0) && !R0_WRITE_EN) begin
          w_state = ST_IDLE;
        end else begin
          w_wb_valid = 1'b1;
          w_wb_addr  = r_rd;
          w_wb_data  = alu_result;
          w_state    = ST_WB;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          w_wb_valid = 1'b0;
          w_state    = ST_IDLE;
        end
      end
      ST_BRANCH: w_state = ST_IDLE;
      default:   w_state = ST_IDLE;
    endcase

    w_instr_ready = (w_state == ST_IDLE);
    w_busy        = (w_state != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instr_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_rs_addr     <= '0;
      r_rt_addr     <= '0;
      r_alu_op      <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_shamt   <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_addr     <= '0;
      r_wb_data     <= '0;
      r_br_valid    <= 1'b0;
      r_br_target   <= '0;
      r_err_illegal <= 1'b0;
      r_err_div0    <= 1'b0;
      r_rd          <= '0;
      r_shamt       <= '0;
      r_imm         <= '0;
      r_pc          <= '0;
      r_op          <= '0;
      r_imm_sel     <= 1'b0;
      r_is_branch   <= 1'b0;
      r_is_div      <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_instr_ready <= w_instr_ready;
      r_busy        <= w_busy;
      r_rs_addr     <= w_rs_addr;
      r_rt_addr     <= w_rt_addr;
      r_alu_op      <= w_alu_op;
      r_alu_a       <= w_alu_a;
      r_alu_b       <= w_alu_b;
      r_alu_shamt   <= w_alu_shamt;
      r_wb_valid    <= w_wb_valid;
      r_wb_addr     <= w_wb_addr;
      r_wb_data     <= w_wb_data;
      r_br_valid    <= w_br_valid;
      r_br_target   <= w_br_target;
      r_err_illegal <= w_err_illegal;
      r_err_div0    <= w_err_div0;
      r_rd          <= w_rd;
      r_shamt       <= w_shamt;
      r_imm         <= w_imm;
      r_pc          <= w_pc;
      r_op          <= w_op;
      r_imm_sel     <= w_imm_sel;
      r_is_branch   <= w_is_branch;
      r_is_div      <= w_is_div;
      r_illegal     <= w_illegal;
    end
  end

  assign instr_ready = r_instr_ready;
  assign busy        = r_busy;
  assign rs_addr     = r_rs_addr;
  assign rt_addr     = r_rt_addr;
  assign alu_op      = r_alu_op;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_shamt   = r_alu_shamt;
  assign wb_valid    = r_wb_valid;
  assign wb_addr     = r_wb_addr;
  assign wb_data     = r_wb_data;
  assign br_valid    = r_br_valid;
  assign br_target   = r_br_target;
  assign err_illegal = r_err_illegal;
  assign err_div0    = r_err_div0;

endmodule

// File: doc/controle_ula.md
CONTROLE_ULA -- requirements
Module: controle_ula

Interface
REQ-001 Parameter R0_WRITE_EN, default 0: when 0, writeback to register 0 SHALL be suppressed.
REQ-002 clock  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 instr_valid  in  1  instruction offered; instr_ready  out  1  block can accept.
REQ-005 instr  in  32  bits [31:26] opcode, [25:21] rd, [20:16] rs, [15:11] rt, [10:6] shamt, [15:0] imm; pc_in  in  32  address of instr.
REQ-006 rs_addr, rt_addr  out  5  register-file read addresses; rs_data, rt_data  in  32  combinational read data.
REQ-007 alu_op  out  5; alu_a, alu_b  out  32; alu_shamt  out  5: ALU operation code and operands.
REQ-008 alu_result  in  32; alu_flag  in  1: ALU data result and branch-condition result.
REQ-009 wb_valid  out  1; wb_ready  in  1; wb_addr  out  5; wb_data  out  32: register writeback handshake.
REQ-010 br_valid  out  1; br_target  out  32: taken-branch redirect.
REQ-011 err_illegal, err_div0  out  1: one-cycle error pulses; busy  out  1  high whenever state is not IDLE.

Function
REQ-012 States: IDLE, READ, EXEC, WB, BRANCH; all outputs registered.
REQ-013 IDLE: instr_ready=1; on instr_valid&instr_ready, capture instr and pc_in, go to READ; otherwise stay.
REQ-014 Decode: opcode[4:0] SHALL drive alu_op; opcode[5]=1 selects sign-extended imm as alu_b, else rt_data.
REQ-015 Legal alu_op range 0x00-0x13; 0x11 (beq) and 0x12 (bne) are branches, always use rt_data, and ignore opcode[5].
REQ-016 Illegal alu_op (>0x13): pulse err_illegal one cycle during READ, no ALU/WB/branch activity, return to IDLE.
REQ-017 READ (1 cycle): drive rs_addr/rt_addr from captured instr; latch rs_data/rt_data at cycle end; go to EXEC.
REQ-018 EXEC (1 cycle): alu_op, alu_a=rs value, alu_b, alu_shamt valid for the whole cycle; latch alu_result and alu_flag at cycle end.
REQ-019 Divide/remainder (0x04, 0x09) with alu_b==0: pulse err_div0 in the cycle after EXEC, skip WB, return to IDLE.
REQ-020 Non-branch, legal, no div0: go to WB; branch: go to BRANCH.
REQ-021 WB: wb_valid=1, wb_addr=rd, wb_data=latched result, all held stable until wb_ready; leave to IDLE in the cycle wb_ready is sampled high.
REQ-022 rd==0 and R0_WRITE_EN==0: WB SHALL be skipped; transition directly to IDLE.
REQ-023 BRANCH (1 cycle): if latched alu_flag=1, br_valid=1 and br_target=pc+1+sext(imm) mod 2^32; otherwise br_valid stays 0; then IDLE.
REQ-024 Minimum latency: accept at cycle N, wb_valid high at cycle N+3; throughput one instruction per 4 cycles with wb_ready tied high.
REQ-025 instr_ready SHALL be 0 in every non-IDLE state; instr_valid during busy is ignored, not queued.
REQ-026 alu_op, alu_a, alu_b, alu_shamt SHALL hold their last values outside EXEC.

Reset
REQ-027 On reset assertion, state SHALL become IDLE immediately; all outputs 0 except instr_ready=1.
REQ-028 Reset mid-operation SHALL discard the in-flight instruction; no wb_valid, br_valid or error pulse afterwards.

Structure
REQ-029 Shared package controle_pkg SHALL hold state encodings, alu_op code constants (0x00-0x13), and field bit positions.
REQ-030 One combinational sub-module decodificador: opcode to alu_op, imm_sel, is_branch, is_div, illegal.

Verification
REQ-031 add (op 0x01), rd=3, rs=5, rt=6, regs 10/20, ALU model -> wb_valid cycle N+3, wb_addr=3, wb_data=30.
REQ-032 beq, rs=rt=7, pc_in=0x100, imm=0xFFFC -> br_valid one cycle, br_target=0x000000FD; rs!=rt -> no br_valid.
REQ-033 div (0x04) with rt value 0 -> err_div0 one-cycle pulse, no wb_valid, instr_ready back to 1.
REQ-034 opcode 0x17 -> err_illegal pulse, no alu_op change, return to IDLE; rd=0 add -> no wb_valid (R0_WRITE_EN=0).
REQ-035 wb_ready held low 5 cycles -> wb_valid, wb_addr, wb_data stable throughout; instr_valid ignored meanwhile.
REQ-036 reset asserted during EXEC -> instr_ready=1 immediately; no wb_valid, br_valid or error pulse follows.
